arb_requester_bank: RTL and testbench

Four-channel requester front end for the 4-way fixed-priority arbiter (priority 3 > 1 > 0 > 2). Each channel accepts a job (start pulse plus beat count), drives its REQ line and holds it until it has received exactly that many granted cycles. It then releases REQ and pulses done. The block sits between local clients and the arbiter: its REQ output drives the arbiter's REQ input, and the arbiter's registered GNT output feeds back in.

---
 rtl/arb_requester_bank.sv | 82 ++++++++
 tb/tb_arb_requester_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester_bank.sv
// Four-channel requester bank feeding a 3>1>0>2 fixed-priority arbiter.
// Each channel holds REQ until it has seen its beat count in granted cycles.
module arb_requester_bank #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    start,
  input  logic [4*LW-1:0] len,
  input  logic [3:0]    GNT,
  output logic [3:0]    REQ,
  output logic [3:0]    beat,
  output logic [3:0]    busy,
  output logic [3:0]    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_ACT,
    S_FIN
  } st_t;

  st_t           st  [4];
  logic [LW-1:0] cnt [4];
  logic [3:0]    g;

  // arbiter bit order is by priority, not by channel number
  assign g = {GNT[3], GNT[0], GNT[2], GNT[1]};

  always_comb begin
    beat = '0;
    for (int i = 0; i < 4; i++)
      beat[i] = (st[i] == S_ACT) && g[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
      REQ  <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        unique case (st[i])
          S_IDLE: begin
            if (start[i]) begin
              if (len[i*LW +: LW] == '0)
                cnt[i] <= LW'(1);
              else
                cnt[i] <= len[i*LW +: LW];
              st[i]   <= S_ARM;
              REQ[i]  <= 1'b1;
              busy[i] <= 1'b1;
            end
          end
          S_ARM: st[i] <= S_ACT;
          S_ACT: begin
            if (g[i]) begin
              cnt[i] <= cnt[i] - LW'(1);
              if (cnt[i] == LW'(1)) begin
                st[i]   <= S_FIN;
                REQ[i]  <= 1'b0;
                done[i] <= 1'b1;
              end
            end
          end
          S_FIN: begin
            st[i]   <= S_IDLE;
            done[i] <= 1'b0;
            busy[i] <= 1'b0;
          end
          default: st[i] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arb_requester_bank.sv
// Bench for arb_requester_bank: arbiter model, job-level reference
// model, per-cycle compare and per-job beat scoreboard.
module tb_arb_requester_bank;

  localparam int LW = 4;

  logic          clk = 0;
  logic          reset = 0;
  logic [3:0]    start = '0;
  logic [4*LW-1:0] len = '0;
  logic [3:0]    GNT = '0;
  logic [3:0]    REQ, beat, busy, done;

  int checks = 0;
  int failures = 0;

  int gbit [4] = '{1, 2, 0, 3};
  int prio [4] = '{3, 1, 0, 2};

  int m_left [4];
  bit m_arm  [4];
  bit m_fin  [4];
  int exp_q  [4][$];
  int obs    [4];
  int dcnt   [4];

  always #5 clk = ~clk;

  arb_requester_bank #(.LW(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .GNT   (GNT),
    .REQ   (REQ),
    .beat  (beat),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_idle(int i);
    return !m_arm[i] && !m_fin[i] && m_left[i] == 0;
  endfunction

  // arbiter and reference model advance together
  always @(posedge clk or negedge reset) begin
    int l;
    logic [3:0] ng;
    bit hit;
    if (!reset) begin
      GNT <= '0;
      for (int i = 0; i < 4; i++) begin
        m_left[i] = 0;
        m_arm[i]  = 0;
        m_fin[i]  = 0;
        obs[i]    = 0;
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_arm[i]) m_arm[i] = 0;
        else if (m_fin[i]) m_fin[i] = 0;
        else if (m_left[i] > 0) begin
          if (GNT[gbit[i]]) begin
            m_left[i]--;
            if (m_left[i] == 0) m_fin[i] = 1;
          end
        end else if (start[i]) begin
          l = int'(len[i*LW +: LW]);
          if (l == 0) l = 1;
          m_left[i] = l;
          m_arm[i]  = 1;
          exp_q[i].push_back(l);
        end
      end
      ng  = GNT;
      hit = 0;
      for (int k = 0; k < 4; k++)
        if (!hit && REQ[prio[k]]) begin
          ng = '0;
          ng[gbit[prio[k]]] = 1'b1;
          hit = 1;
        end
      GNT <= ng;
    end
  end

  always @(negedge clk) begin
    logic [3:0] er, eb, ebu, ed;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        er[i]  = m_arm[i] || m_left[i] > 0;
        ebu[i] = !m_idle(i);
        ed[i]  = m_fin[i];
        eb[i]  = m_left[i] > 0 && !m_arm[i] &&
                 GNT[gbit[i]];
      end
      chk("REQ", 32'(REQ), 32'(er));
      chk("busy", 32'(busy), 32'(ebu));
      chk("done", 32'(done), 32'(ed));
      chk("beat", 32'(beat), 32'(eb));
      chk("beat_onehot", 32'($onehot0(beat)), 1);
      for (int i = 0; i < 4; i++) begin
        obs[i] += int'(beat[i]);
        if (done[i]) begin
          dcnt[i]++;
          chk("job_queued", 32'(exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0)
            chk("job_beats", 32'(obs[i]),
                32'(exp_q[i].pop_front()));
          obs[i] = 0;
        end
      end
    end
  end

  task automatic pulse(logic [3:0] s,
                       logic [4*LW-1:0] l);
    start = s;
    len   = l;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    int d1;
    start = 4'hF;
    len   = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_REQ", 32'(REQ), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_beat", 32'(beat), 0);
    #2 reset = 1;
    start = '0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    // single ch3 job, len 2
    pulse(4'b1000, 16'h2000);
    chk("t1_req", 32'(REQ), 32'h8);
    chk("t1_arm_beat", 32'(beat), 0);
    @(negedge clk);
    chk("t1_beat1", 32'(beat), 32'h8);
    @(negedge clk);
    chk("t1_beat2", 32'(beat), 32'h8);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'h8);
    chk("t1_req_off", 32'(REQ), 0);
    chk("t1_dead", 32'(beat), 0);
    @(negedge clk);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_done_off", 32'(done), 0);
    wait_idle(20);

    // contention ch0 and ch3
    pulse(4'b1001, 16'h2002);
    wait_idle(40);

    // preemption of ch2 by ch3
    pulse(4'b0100, 16'h0400);
    @(negedge clk);
    pulse(4'b1000, 16'h1000);
    wait_idle(40);

    // stale grant after ch3 release
    pulse(4'b1000, 16'h1000);
    wait_idle(20);
    chk("stale_gnt", 32'(GNT), 32'h8);
    pulse(4'b1010, 16'h1010);
    chk("stale_arm", 32'(beat), 0);
    wait_idle(20);

    // len 0 and starts outside IDLE
    d1 = dcnt[1];
    pulse(4'b0010, 16'h0000);
    @(negedge clk);
    pulse(4'b0010, 16'h0050);
    pulse(4'b0010, 16'h0050);
    wait_idle(20);
    chk("len0_dones", 32'(dcnt[1] - d1), 1);

    // random traffic with a mid-job reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 4'($urandom_range(0, 15) &
                 $urandom_range(0, 15));
      len   = 16'($urandom);
      if (c == 1500) begin
        #2 reset = 0;
        #1 chk("abort_REQ", 32'(REQ), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        #2 reset = 1;
      end
    end
    @(negedge clk);
    start = '0;
    wait_idle(300);
    for (int i = 0; i < 4; i++)
      chk("queue_empty", 32'(exp_q[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
